mio_arbiter: RTL
================

MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access latency in cycles (legal 1..15).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports cpu_req, cpu_we, input, 1 each, meaning CPU access request and write enable.
REQ-005 SHALL have ports cpu_addr, cpu_wdata, input, 32 each, meaning CPU address and write data.
REQ-006 SHALL have ports cpu_rdata, output, 32, and cpu_ready, output, 1, meaning CPU read data and completion pulse (drives the controller's MIO_ready).
REQ-007 SHALL have ports dev_req, dev_we, input, 1 each, meaning second-master request and write enable.
REQ-008 SHALL have ports dev_addr, dev_wdata, input, 32 each, meaning second-master address and write data.
REQ-009 SHALL have ports dev_rdata, output, 32, and dev_ready, output, 1, meaning second-master read data and completion pulse.
REQ-010 SHALL have ports mem_en, mem_we, output, 1 each; mem_addr, mem_wdata, output, 32 each, meaning the shared memory/IO port.
REQ-011 SHALL have port mem_rdata, input, 32, meaning memory read data.
REQ-012 SHALL have ports grant, output, 2 (bit0 CPU, bit1 dev, one-hot or zero), and busy, output, 1.

Function
REQ-013 SHALL implement three states: IDLE, ACCESS, DONE.
REQ-014 SHALL sample cpu_req/dev_req only in IDLE; requests in ACCESS or DONE are ignored until IDLE.
REQ-015 SHALL, in IDLE with one request, grant that requester; with both, grant the one not in last_grant (round-robin).
REQ-016 SHALL, on IDLE->ACCESS, register addr/wdata/we of the granted requester into mem_addr/mem_wdata/mem_we, set grant, and load counter with MEM_LAT-1.
REQ-017 SHALL hold mem_en=1 and mem_addr/mem_wdata/mem_we stable for exactly MEM_LAT ACCESS cycles, decrementing the counter each cycle.
REQ-018 SHALL, in the ACCESS cycle where counter==0 and mem_we==0, capture mem_rdata into the granted requester's rdata register; writes leave both rdata registers unchanged.
REQ-019 SHALL go ACCESS->DONE when counter==0; in DONE assert the granted requester's ready for exactly one cycle, mem_en=0, update last_grant, then go to IDLE.
REQ-020 SHALL give latency: request visible in IDLE cycle 0 -> ready high in cycle MEM_LAT+1; IDLE lasts at least one cycle between transactions.
REQ-021 SHALL keep cpu_rdata/dev_rdata holding their last captured value until the next read by the same requester.
REQ-022 SHALL drive busy=1 in ACCESS and DONE, 0 in IDLE; grant=0 in IDLE.
REQ-023 SHALL treat a request still held in the IDLE cycle after ready as a new transaction (requesters drop req the cycle after ready).
REQ-024 SHALL never assert cpu_ready and dev_ready in the same cycle.
REQ-025 SHALL never have ready asserted for a requester that was not granted.

Reset
REQ-026 SHALL, on reset at any clock edge (including mid-ACCESS or DONE), enter IDLE, abort the transaction without a ready pulse, and drive mem_en, mem_we, cpu_ready, dev_ready, busy, grant to 0.
REQ-027 SHALL reset mem_addr, mem_wdata, cpu_rdata, dev_rdata, counter to 0, and last_grant to dev so the CPU wins the first tie.

Verification
REQ-028 CPU read, MEM_LAT=2, cpu_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en cycles 1-2, cpu_ready cycle 3, cpu_rdata=0xDEADBEEF, dev_rdata=0.
REQ-029 CPU write 0x12345678 to 0x200 -> mem_we=1 with mem_wdata=0x12345678 for 2 cycles; cpu_rdata unchanged; cpu_ready cycle 3.
REQ-030 Both request from reset, held continuously -> grants alternate CPU, dev, CPU, dev; each ready one cycle; no simultaneous readys.
REQ-031 dev_req during CPU ACCESS -> ignored until IDLE, then dev granted; dev_ready at MEM_LAT+1 cycles after that IDLE.
REQ-032 reset asserted in second ACCESS cycle -> next cycle IDLE, mem_en=0, no ready pulse, all outputs 0; following CPU/dev tie grants CPU.
REQ-033 MEM_LAT=1 and MEM_LAT=15 reads -> ready in cycle 2 and cycle 16 respectively, correct data captured.

Source files
------------

// File: rtl/mio_arbiter.sv
// Two-master arbiter for a shared memory/IO port. It runs an IDLE -> ACCESS -> DONE sequence and uses
// round-robin tie-breaking. Each transaction holds the port for MEM_LAT cycles and then pulses ready once.
module mio_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dev_req,
  input  logic        dev_we,
  input  logic [31:0] dev_addr,
  input  logic [31:0] dev_wdata,
  output logic [31:0] dev_rdata,
  output logic        dev_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_dev_q, last_dev_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dev_rdata_q, dev_rdata_d;
  logic        pick_dev;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_dev_d  = last_dev_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    pick_dev    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dev_req) begin
          // On a tie, the master that did not win last time gets the port.
          pick_dev = dev_req && (!cpu_req || !last_dev_q);
          grant_d  = pick_dev ? 2'b10 : 2'b01;
          addr_d   = pick_dev ? dev_addr  : cpu_addr;
          wdata_d  = pick_dev ? dev_wdata : cpu_wdata;
          we_d     = pick_dev ? dev_we    : cpu_we;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q[1]) dev_rdata_d = mem_rdata;
            else            cpu_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_dev_d = grant_q[1];
        grant_d    = '0;
        state_d    = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      last_dev_q  <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_dev_q  <= last_dev_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dev_rdata = dev_rdata_q;
  assign cpu_ready = (state_q == DONE) && grant_q[0];
  assign dev_ready = (state_q == DONE) && grant_q[1];
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
